reg_file_16x16: RTL and testbench



---
 rtl/datapath_defs.sv | 8 +
 rtl/reg_file_rd_port.sv | 35 +++
 rtl/reg_file_16x16.sv | 86 ++++++++
 tb/tb_reg_file_16x16.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/datapath_defs.sv
// Shared datapath constants for the register file, operand mux and ALU.
package datapath_defs;
    localparam int         DATA_W    = 16;
    localparam int         ADDR_W    = 4;
    localparam logic [3:0] REG_ZERO  = 4'd0;
    localparam logic [3:0] REG_AUX   = 4'd15;
    localparam logic [15:0] RESET_VAL = 16'h0000;
endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: address decode, R0 masking and, with
// REGFILE_BYPASS_EN defined, same-cycle write-through forwarding.
module reg_file_rd_port #(
    parameter int DATA_W = datapath_defs::DATA_W,
    parameter int ADDR_W = datapath_defs::ADDR_W
) (
    input  logic [ADDR_W-1:0]               rd_addr,
    input  logic [(2**ADDR_W)*DATA_W-1:0]   regs_flat,
`ifdef REGFILE_BYPASS_EN
    input  logic                            wr_en,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            r15_wr_en,
    input  logic [DATA_W-1:0]               r15_wr_data,
`endif
    output logic [DATA_W-1:0]               rd_data
);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(datapath_defs::REG_ZERO);
    localparam logic [ADDR_W-1:0] AUX_ADDR  = ADDR_W'(datapath_defs::REG_AUX);

    always_comb begin
        rd_data = regs_flat[int'(rd_addr)*DATA_W +: DATA_W];
        if (rd_addr == ZERO_ADDR) begin
            rd_data = '0;
        end
`ifdef REGFILE_BYPASS_EN
        // Auxiliary port forwards first so forwarding agrees with the R15 write priority.
        if (r15_wr_en && rd_addr == AUX_ADDR) begin
            rd_data = r15_wr_data;
        end else if (wr_en && wr_addr == rd_addr && rd_addr != ZERO_ADDR) begin
            rd_data = wr_data;
        end
`endif
    end
endmodule

// File: rtl/reg_file_16x16.sv
// 16x16 register file: two read ports, one main write port, auxiliary R15 write port.
// Optional write-through forwarding on the read ports via REGFILE_BYPASS_EN.
module reg_file_16x16 #(
    parameter int              DATA_W    = datapath_defs::DATA_W,
    parameter int              ADDR_W    = datapath_defs::ADDR_W,
    parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(datapath_defs::RESET_VAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              r15_wr_en,
    input  logic [DATA_W-1:0] r15_wr_data,
    output logic [DATA_W-1:0] r15_out
);
    localparam int DEPTH   = 2**ADDR_W;
    localparam int AUX_IDX = int'(datapath_defs::REG_AUX);

    // R0 has no storage; slots 1..DEPTH-1 are real registers.
    logic [DATA_W-1:0]       regs_q [1:DEPTH-1];
    logic [DATA_W-1:0]       regs_d [1:DEPTH-1];
    logic [DEPTH*DATA_W-1:0] regs_flat;

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < DEPTH; i++) begin
            if (wr_en && wr_addr == ADDR_W'(i)) begin
                regs_d[i] = wr_data;
            end
        end
        // Applied last so the auxiliary result wins an R15 collision.
        if (r15_wr_en) begin
            regs_d[AUX_IDX] = r15_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 1; i < DEPTH; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    assign r15_out = regs_q[AUX_IDX];

    reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port_a (
        .rd_addr     (rd_addr_a),
        .regs_flat   (regs_flat),
`ifdef REGFILE_BYPASS_EN
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .r15_wr_en   (r15_wr_en),
        .r15_wr_data (r15_wr_data),
`endif
        .rd_data     (rd_data_a)
    );

    reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port_b (
        .rd_addr     (rd_addr_b),
        .regs_flat   (regs_flat),
`ifdef REGFILE_BYPASS_EN
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .r15_wr_en   (r15_wr_en),
        .r15_wr_data (r15_wr_data),
`endif
        .rd_data     (rd_data_b)
    );
endmodule

// File: tb/tb_reg_file_16x16.sv
// Directed table-driven bench for reg_file_16x16 plus hand sequences for reset,
// read-during-write and R15 collision; expectations follow REGFILE_BYPASS_EN.
module tb_reg_file_16x16;
    logic        clk;
    logic        rst;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        r15_wr_en;
    logic [15:0] r15_wr_data;
    logic [15:0] r15_out;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_16x16 dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .rd_data_a   (rd_data_a),
        .rd_data_b   (rd_data_b),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .r15_wr_en   (r15_wr_en),
        .r15_wr_data (r15_wr_data),
        .r15_out     (r15_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        we15;
        logic [15:0] wd15;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic [15:0] exp_r15;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [15:0] exp_pre;

        //        we   wa     wd        we15  wd15      ra     rb     exp_a     exp_b     exp_r15
        vecs[0] = '{1'b1, 4'd3,  16'hFFFE, 1'b0, 16'h0000, 4'd3,  4'd0,  16'hFFFE, 16'h0000, 16'h0000};
        vecs[1] = '{1'b1, 4'd7,  16'h0001, 1'b0, 16'h0000, 4'd3,  4'd7,  16'hFFFE, 16'h0001, 16'h0000};
        vecs[2] = '{1'b1, 4'd0,  16'hBEEF, 1'b0, 16'h0000, 4'd0,  4'd0,  16'h0000, 16'h0000, 16'h0000};
        vecs[3] = '{1'b1, 4'd15, 16'hAAAA, 1'b1, 16'h5555, 4'd15, 4'd15, 16'h5555, 16'h5555, 16'h5555};
        vecs[4] = '{1'b1, 4'd2,  16'h00FF, 1'b1, 16'h1111, 4'd2,  4'd15, 16'h00FF, 16'h1111, 16'h1111};
        vecs[5] = '{1'b0, 4'd3,  16'h1234, 1'b0, 16'h9999, 4'd3,  4'd7,  16'hFFFE, 16'h0001, 16'h1111};
        vecs[6] = '{1'b1, 4'd15, 16'hABCD, 1'b0, 16'h0000, 4'd15, 4'd2,  16'hABCD, 16'h00FF, 16'hABCD};
        vecs[7] = '{1'b1, 4'd9,  16'h8000, 1'b0, 16'h0000, 4'd9,  4'd9,  16'h8000, 16'h8000, 16'hABCD};
        vecs[8] = '{1'b0, 4'd0,  16'h0000, 1'b1, 16'h0F0F, 4'd15, 4'd0,  16'h0F0F, 16'h0000, 16'h0F0F};
        vecs[9] = '{1'b1, 4'd1,  16'h7FFF, 1'b0, 16'h0000, 4'd1,  4'd3,  16'h7FFF, 16'hFFFE, 16'h0F0F};

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        r15_wr_en = 1'b0; r15_wr_data = '0; rd_addr_a = 4'd5; rd_addr_b = 4'd15;
        #2;
        check("reset_rd_a", rd_data_a, 16'h0000);
        check("reset_rd_b", rd_data_b, 16'h0000);
        check("reset_r15",  r15_out,   16'h0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            r15_wr_en = vecs[i].we15; r15_wr_data = vecs[i].wd15;
            rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
            @(posedge clk);
            #1;
            wr_en = 1'b0; r15_wr_en = 1'b0;
            #1;
            check($sformatf("vec%0d_rd_a", i), rd_data_a, vecs[i].exp_a);
            check($sformatf("vec%0d_rd_b", i), rd_data_b, vecs[i].exp_b);
            check($sformatf("vec%0d_r15",  i), r15_out,   vecs[i].exp_r15);
        end

        // Asynchronous reset mid-cycle wipes a fresh write without a clock edge.
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234; rd_addr_a = 4'd5; rd_addr_b = 4'd3;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        #1;
        check("pre_rst_r5", rd_data_a, 16'h1234);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_r5",  rd_data_a, 16'h0000);
        check("async_rst_r3",  rd_data_b, 16'h0000);
        check("async_rst_r15", r15_out,   16'h0000);

        // A write presented while reset is held is discarded.
        wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h5A5A; rd_addr_a = 4'd6;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_discard_r6", rd_data_a, 16'h0000);

        // First edge with rst low accepts a write.
        wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h0042;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        #1;
        check("first_write_r6", rd_data_a, 16'h0042);

        // Read-during-write on R4 and R15 (aux port), before and after the edge.
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'hC0DE; rd_addr_a = 4'd4;
        r15_wr_en = 1'b1; r15_wr_data = 16'h2222; rd_addr_b = 4'd15;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 16'hC0DE;
`else
        exp_pre = 16'h0000;
`endif
        check("rdw_pre_r4", rd_data_a, exp_pre);
`ifdef REGFILE_BYPASS_EN
        exp_pre = 16'h2222;
`else
        exp_pre = 16'h0000;
`endif
        check("rdw_pre_r15_port", rd_data_b, exp_pre);
        check("rdw_pre_r15_out",  r15_out,   16'h0000);
        @(posedge clk);
        #1;
        wr_en = 1'b0; r15_wr_en = 1'b0;
        #1;
        check("rdw_post_r4",  rd_data_a, 16'hC0DE);
        check("rdw_post_r15", rd_data_b, 16'h2222);
        check("rdw_post_r15_out", r15_out, 16'h2222);

        // R0 write never forwards; R15 collision forwards the aux value.
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hBEEF; rd_addr_a = 4'd0; rd_addr_b = 4'd4;
        #1;
        check("r0_pre", rd_data_a, 16'h0000);
        check("r4_unaffected", rd_data_b, 16'hC0DE);
        @(posedge clk);
        #1;
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 16'hAAAA;
        r15_wr_en = 1'b1; r15_wr_data = 16'h5555; rd_addr_a = 4'd15;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 16'h5555;
`else
        exp_pre = 16'h2222;
`endif
        check("coll_pre_r15", rd_data_a, exp_pre);
        @(posedge clk);
        #1;
        wr_en = 1'b0; r15_wr_en = 1'b0;
        #1;
        check("coll_post_r15", rd_data_a, 16'h5555);
        check("coll_post_r15_out", r15_out, 16'h5555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
